imem_loader: RTL and testbench

- Program loader: the writing side of the instruction memory that the MIPS core fetches from.
- Accepts a byte stream over a valid/ready handshake and frames it as: 4-byte big-endian word count N, then N big-endian 32-bit instruction words, then a 1-byte XOR checksum.
- Writes each assembled word into the instruction memory write port.
- Holds the core in reset while a load is in progress and after a failed load.

---
 rtl/imem_loader.sv | 146 ++++++++++++++
 tb/tb_imem_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader that writes the instruction memory from a framed byte stream.
// Frame layout: a 4-byte big-endian word count, then the words, then an XOR checksum.
//
// state | meaning
// IDLE  | out of reset, core released, waiting for start
// HDR   | collecting the 4-byte word count
// DATA  | assembling words and writing them to imem
// CSUM  | waiting for the checksum byte
// DONE  | load good, core released
// ERR   | load bad, core held in reset
module imem_loader #(
    parameter int          IMEM_WORDS = 256,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_resetN,
    output logic        busy,
    output logic        load_done,
    output logic        load_err
);

    localparam int IDX_W = $clog2(IMEM_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [IDX_W-1:0]   word_idx;
    logic [IDX_W-1:0]   n_words;
    logic [7:0]         csum;
    logic [23:0]        shift_sr;

    logic               accept;
    logic [31:0]        shifted;
    logic [31:0]        idx_ext;
    logic [31:0]        n_ext;

    // Header count and data words share one shift register; each always spans exactly 4 bytes.
    assign accept  = in_valid & in_ready;
    assign shifted = {shift_sr, in_data};
    assign idx_ext = 32'(word_idx);
    assign n_ext   = 32'(n_words);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            n_words    <= '0;
            csum       <= 8'd0;
            shift_sr   <= 24'd0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            cpu_resetN <= 1'b0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (start) begin
                // A byte accepted alongside start is deliberately dropped.
                state      <= S_HDR;
                byte_cnt   <= 2'd0;
                word_idx   <= '0;
                n_words    <= '0;
                csum       <= 8'd0;
                in_ready   <= 1'b1;
                busy       <= 1'b1;
                cpu_resetN <= 1'b0;
                load_done  <= 1'b0;
                load_err   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: cpu_resetN <= 1'b1;
                    S_HDR: begin
                        if (accept) begin
                            shift_sr <= shifted[23:0];
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                if (shifted > 32'(IMEM_WORDS)) begin
                                    state    <= S_ERR;
                                    load_err <= 1'b1;
                                    in_ready <= 1'b0;
                                    busy     <= 1'b0;
                                end else begin
                                    n_words <= shifted[IDX_W-1:0];
                                    state   <= (shifted == 32'd0) ? S_CSUM : S_DATA;
                                end
                            end
                        end
                    end
                    S_DATA: begin
                        if (accept) begin
                            shift_sr <= shifted[23:0];
                            csum     <= csum ^ in_data;
                            byte_cnt <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                imem_we    <= 1'b1;
                                imem_addr  <= BASE_ADDR + (idx_ext << 2);
                                imem_wdata <= shifted;
                                word_idx   <= word_idx + IDX_W'(1);
                                if (idx_ext + 32'd1 == n_ext)
                                    state <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (accept) begin
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            if (in_data == csum) begin
                                state      <= S_DONE;
                                load_done  <= 1'b1;
                                cpu_resetN <= 1'b1;
                            end else begin
                                state    <= S_ERR;
                                load_err <= 1'b1;
                            end
                        end
                    end
                    S_DONE: ;
                    S_ERR:  ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a frame-position model checked every cycle, plus literal
// expectations on the captured write list and status after each directed load.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready, imem_we, cpu_resetN, busy, load_done, load_err;
    logic [31:0] imem_addr, imem_wdata;

    imem_loader #(.IMEM_WORDS(256), .BASE_ADDR(BASE)) dut (
        .clk(clk), .resetN(resetN), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_resetN(cpu_resetN),
        .busy(busy), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Model: position in the frame decides what each accepted byte means.
    bit          m_active, m_done, m_err, m_cpu, m_started, m_we;
    int unsigned m_pos, m_n;
    logic [7:0]  m_csum;
    logic [31:0] m_word, m_addr, m_wdata;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function void model_reset();
        m_active = 0; m_done = 0; m_err = 0; m_cpu = 0; m_started = 0; m_we = 0;
        m_pos = 0; m_n = 0; m_csum = 8'd0; m_word = 32'd0;
    endfunction

    function void model_step(input bit st, input bit acc, input logic [7:0] b);
        m_we = 0;
        if (st) begin
            m_active = 1; m_pos = 0; m_n = 0; m_csum = 8'd0;
            m_done = 0; m_err = 0; m_cpu = 0; m_started = 1;
        end else if (!m_started) begin
            m_cpu = 1;
        end else if (m_active && acc) begin
            if (m_pos < 4) begin
                m_n = (m_n << 8) | 32'(b);
                m_pos++;
                if (m_pos == 4 && m_n > 256) begin
                    m_active = 0;
                    m_err = 1;
                end
            end else if (m_pos < 4 + 4 * m_n) begin
                m_word = (m_word << 8) | 32'(b);
                m_csum = m_csum ^ b;
                m_pos++;
                if ((m_pos - 4) % 4 == 0) begin
                    m_we = 1;
                    m_addr = BASE + 4 * ((m_pos - 4) / 4 - 1);
                    m_wdata = m_word;
                end
            end else begin
                m_active = 0;
                if (b == m_csum) begin
                    m_done = 1;
                    m_cpu = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!resetN) begin
            model_reset();
            chk("rst_in_ready", in_ready, 0);
            chk("rst_imem_we", imem_we, 0);
            chk("rst_imem_addr", imem_addr, 0);
            chk("rst_imem_wdata", imem_wdata, 0);
            chk("rst_cpu_resetN", cpu_resetN, 0);
            chk("rst_busy", busy, 0);
            chk("rst_load_done", load_done, 0);
            chk("rst_load_err", load_err, 0);
        end else begin
            chk("in_ready", in_ready, m_active);
            chk("busy", busy, m_active);
            chk("cpu_resetN", cpu_resetN, m_cpu);
            chk("load_done", load_done, m_done);
            chk("load_err", load_err, m_err);
            chk("imem_we", imem_we, m_we);
            if (m_we) begin
                chk("imem_addr", imem_addr, m_addr);
                chk("imem_wdata", imem_wdata, m_wdata);
            end
            if (imem_we) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
            end
            model_step(start, in_valid && in_ready, in_data);
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int g = 0;
        int t = 0;
        while (gap > 0 && $urandom_range(0, 99) < gap && g < 8) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
            g++;
        end
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 100) begin
                compared++;
                mismatched++;
                $display("FAIL handshake_timeout: in_ready stayed %b, required 1", in_ready);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] s[$], input int gap);
        foreach (s[i]) send_byte(s[i], gap);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_wr_count"}, wr_data.size(), 2);
        if (wr_data.size() >= 2) begin
            chk({tag, "_addr0"}, wr_addr[0], 32'h0);
            chk({tag, "_data0"}, wr_data[0], 32'h2008_0005);
            chk({tag, "_addr1"}, wr_addr[1], 32'h4);
            chk({tag, "_data1"}, wr_data[1], 32'h8C09_0004);
        end
    endtask

    logic [7:0] s_ok[$], s_bad[$], s_big[$], s_zero[$], s_abort[$], s_one[$], s_part[$];

    initial begin
        s_ok    = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
        s_bad   = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                    8'h8C, 8'h09, 8'h00, 8'h04, 8'hAD};
        s_big   = '{8'h00, 8'h00, 8'h01, 8'h01};
        s_zero  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        s_abort = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
        s_one   = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        s_part  = '{8'h00, 8'h00, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF};

        idle(3);
        resetN = 1'b1;
        idle(1);
        chk("cpu_released_after_reset", cpu_resetN, 1);

        // Good two-word load
        clear_writes();
        pulse_start();
        send_seq(s_ok, 0);
        idle(3);
        check_two_writes("ok");
        chk("ok_done", load_done, 1);
        chk("ok_err", load_err, 0);
        chk("ok_cpu", cpu_resetN, 1);

        // Bad checksum
        clear_writes();
        pulse_start();
        send_seq(s_bad, 0);
        idle(3);
        check_two_writes("bad");
        chk("bad_done", load_done, 0);
        chk("bad_err", load_err, 1);
        chk("bad_cpu", cpu_resetN, 0);

        // Oversized header
        clear_writes();
        pulse_start();
        send_seq(s_big, 0);
        idle(3);
        chk("big_wr_count", wr_data.size(), 0);
        chk("big_err", load_err, 1);
        chk("big_ready", in_ready, 0);

        // Empty program
        clear_writes();
        pulse_start();
        send_seq(s_zero, 0);
        idle(3);
        chk("zero_wr_count", wr_data.size(), 0);
        chk("zero_done", load_done, 1);
        chk("zero_cpu", cpu_resetN, 1);

        // Sparse in_valid
        clear_writes();
        pulse_start();
        send_seq(s_ok, 60);
        idle(3);
        check_two_writes("gap");
        chk("gap_done", load_done, 1);

        // Abort after 6 data bytes, then a one-word load
        clear_writes();
        pulse_start();
        send_seq(s_abort, 0);
        pulse_start();
        send_seq(s_one, 0);
        idle(3);
        chk("abort_wr_count", wr_data.size(), 2);
        if (wr_data.size() >= 2) begin
            chk("abort_first_data", wr_data[0], 32'h2008_0005);
            chk("abort_last_addr", wr_addr[1], 32'h0);
            chk("abort_last_data", wr_data[1], 32'h1122_3344);
        end
        chk("abort_done", load_done, 1);

        // Reset while a write strobe is pending
        clear_writes();
        pulse_start();
        send_seq(s_part, 0);
        resetN = 1'b0;
        #1;
        chk("midrst_we", imem_we, 0);
        chk("midrst_busy", busy, 0);
        idle(2);
        resetN = 1'b1;
        idle(2);
        chk("midrst_cpu", cpu_resetN, 1);
        chk("midrst_ready", in_ready, 0);
        chk("midrst_done", load_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
